clk_period_meter: RTL and testbench

Measures an asynchronous, slow square wave such as a divided clock or an external tick, using the system clock as the time base. Reports the period and high time, both in system-clock cycles, with a one-cycle valid strobe. It also tracks lock and loss-of-signal. It is the receiving end of the clock-division path: one block produces a slow clock from `clk`, and this block recovers its ratio and duty cycle in `clk` cycles. Typical uses are self-check and frequency monitoring.

---
 rtl/clk_meas_pkg.sv | 11 +
 rtl/sync_edge_detect.sv | 35 +++
 rtl/clk_period_meter.sv | 140 ++++++++++++++
 tb/tb_clk_period_meter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_meas_pkg.sv
// Shared types and defaults for the clock period meter.
package clk_meas_pkg;

   localparam int CNT_W_DEF = 32;

   typedef enum logic {
      SEEK = 1'b0,
      RUN  = 1'b1
   } meas_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous level into the clk domain and flags its edges
// using one history flop behind the synchronizer chain.
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_async,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   // synchronizer chain plus one history stage for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   // edge flags compare the synced level against its previous value
   always_comb begin
      level = sync_q[SYNC_STAGES-1];
      rise  = level & ~hist_q;
      fall  = ~level & hist_q;
   end

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk
// cycles, with lock tracking and loss-of-signal detection.
//
// state | meaning
// SEEK  | idle, counter held at 0, waiting for a rising edge to start
// RUN   | counting cycles since the last rising edge
module clk_period_meter
   import clk_meas_pkg::*;
#(
   parameter int          CNT_W       = CNT_W_DEF,
   parameter int unsigned TIMEOUT     = 2_000_000,
   parameter int          SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             meas_valid,
   output logic             locked,
   output logic             timeout
);

   // The loss-of-signal timer runs down from TIMEOUT-1 alongside the
   // measurement counter, so reaching zero coincides with cnt == TIMEOUT.
   localparam logic [CNT_W-1:0] TMR_LOAD = CNT_W'(TIMEOUT - 1);

   logic sig_rise;
   logic sig_fall;
   logic sig_level_unused;   // the synced level itself is not needed here

   meas_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] tmr_q, tmr_d;
   logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic             mv_q, mv_d;
   logic             locked_q, locked_d;
   logic             to_q, to_d;

   sync_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .rst     (rst),
      .d_async (sig_in),
      .level   (sig_level_unused),
      .rise    (sig_rise),
      .fall    (sig_fall)
   );

   // state, counters and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= SEEK;
         cnt_q    <= '0;
         tmr_q    <= '0;
         hi_lat_q <= '0;
         period_q <= '0;
         high_q   <= '0;
         mv_q     <= 1'b0;
         locked_q <= 1'b0;
         to_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         tmr_q    <= tmr_d;
         hi_lat_q <= hi_lat_d;
         period_q <= period_d;
         high_q   <= high_d;
         mv_q     <= mv_d;
         locked_q <= locked_d;
         to_q     <= to_d;
      end
   end

   // next-state and measurement logic; rise beats timeout in the same cycle
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tmr_d    = tmr_q;
      hi_lat_d = hi_lat_q;
      period_d = period_q;
      high_d   = high_q;
      mv_d     = 1'b0;
      locked_d = locked_q;
      to_d     = 1'b0;

      if (!en) begin
         state_d  = SEEK;
         cnt_d    = '0;
         locked_d = 1'b0;
      end else begin
         case (state_q)
            SEEK: begin
               cnt_d = '0;
               if (sig_rise) begin
                  cnt_d    = CNT_W'(1);
                  tmr_d    = TMR_LOAD;
                  hi_lat_d = '0;
                  state_d  = RUN;
               end
            end
            RUN: begin
               cnt_d = cnt_q + CNT_W'(1);
               tmr_d = tmr_q - CNT_W'(1);
               if (sig_fall) begin
                  hi_lat_d = cnt_q;
               end
               if (sig_rise) begin
                  period_d = cnt_q;
                  high_d   = hi_lat_q;
                  mv_d     = 1'b1;
                  locked_d = 1'b1;
                  cnt_d    = CNT_W'(1);
                  tmr_d    = TMR_LOAD;
               end else if (tmr_q == '0) begin
                  to_d     = 1'b1;
                  locked_d = 1'b0;
                  cnt_d    = '0;
                  state_d  = SEEK;
               end
            end
            default: begin
               state_d = SEEK;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign period     = period_q;
   assign high_time  = high_q;
   assign meas_valid = mv_q;
   assign locked     = locked_q;
   assign timeout    = to_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: two instances share the stimulus, one
// with a long loss-of-signal limit for slow waves and one with a limit of 100.
module tb_clk_period_meter;

   logic clk = 1'b0;
   logic rst;
   logic en;
   logic sig_in;

   logic [31:0] l_period, l_high;
   logic        l_mv, l_locked, l_to;
   logic [31:0] s_period, s_high;
   logic        s_mv, s_locked, s_to;

   int n_tests = 0;
   int n_fail  = 0;

   int cyc = 0;
   int l_mv_cnt = 0;
   int s_mv_cnt = 0, s_mv_last = 0, s_mv_prev = 0;
   int s_to_cnt = 0, s_to_last = 0;
   int x_cnt = 0;
   bit x_watch = 1'b0;

   int mv0, to0;

   always #5 clk = ~clk;

   clk_period_meter #(
      .CNT_W       (32),
      .TIMEOUT     (4000),
      .SYNC_STAGES (2)
   ) dut_long (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .sig_in     (sig_in),
      .period     (l_period),
      .high_time  (l_high),
      .meas_valid (l_mv),
      .locked     (l_locked),
      .timeout    (l_to)
   );

   clk_period_meter #(
      .CNT_W       (32),
      .TIMEOUT     (100),
      .SYNC_STAGES (2)
   ) dut_short (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .sig_in     (sig_in),
      .period     (s_period),
      .high_time  (s_high),
      .meas_valid (s_mv),
      .locked     (s_locked),
      .timeout    (s_to)
   );

   // cycle count for strobe timestamps
   always @(posedge clk) cyc <= cyc + 1;

   // strobe bookkeeping and X watch, sampled away from the active edge
   always @(negedge clk) begin
      if (l_mv === 1'b1) l_mv_cnt++;
      if (s_mv === 1'b1) begin
         s_mv_cnt++;
         s_mv_prev = s_mv_last;
         s_mv_last = cyc;
      end
      if (s_to === 1'b1) begin
         s_to_cnt++;
         s_to_last = cyc;
      end
      if (x_watch && $isunknown({l_period, l_high, l_mv, l_locked, l_to,
                                 s_period, s_high, s_mv, s_locked, s_to}))
         x_cnt++;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d", tag, obs, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wave(input int per, input int hi, input int n);
      for (int k = 0; k < n; k++) begin
         sig_in = 1'b1;
         tick(hi);
         sig_in = 1'b0;
         tick(per - hi);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(2);
   endtask

   initial begin
      rst    = 1'b1;
      en     = 1'b1;
      sig_in = 1'b0;
      tick(3);
      check_eq("rst_period",  s_period, 0);
      check_eq("rst_high",    s_high,   0);
      check_eq("rst_mv",      {31'd0, s_mv},     0);
      check_eq("rst_locked",  {31'd0, s_locked}, 0);
      check_eq("rst_timeout", {31'd0, s_to},     0);
      rst = 1'b0;
      x_watch = 1'b1;
      tick(2);

      // steady 20/10 wave: six rises give five measurements
      mv0 = l_mv_cnt;
      wave(20, 10, 6);
      check_eq("steady_mv_count", l_mv_cnt - mv0, 5);
      check_eq("steady_period",   l_period, 20);
      check_eq("steady_high",     l_high,   10);
      check_eq("steady_locked",   {31'd0, l_locked}, 1);
      check_eq("steady_spacing",  s_mv_last - s_mv_prev, 20);
      check_eq("steady_s_period", s_period, 20);

      // ratio and duty change: 2000/500 then 6/2
      wave(2000, 500, 3);
      check_eq("div2000_period", l_period, 2000);
      check_eq("div2000_high",   l_high,   500);
      wave(6, 2, 4);
      check_eq("div6_period", l_period, 6);
      check_eq("div6_high",   l_high,   2);
      check_eq("div6_locked", {31'd0, l_locked}, 1);

      // loss of signal: input stuck high after a rise
      do_reset();
      wave(20, 10, 3);
      to0 = s_to_cnt;
      sig_in = 1'b1;
      for (int i = 0; i < 200 && s_to_cnt == to0; i++) tick(1);
      check_eq("to_count",       s_to_cnt - to0, 1);
      check_eq("to_distance",    s_to_last - s_mv_last, 100);
      check_eq("to_locked",      {31'd0, s_locked}, 0);
      check_eq("to_period_hold", s_period, 20);
      check_eq("to_high_hold",   s_high,   10);
      check_eq("to_strobe_end",  {31'd0, s_to}, 0);
      sig_in = 1'b0;
      tick(10);
      mv0 = s_mv_cnt;
      wave(30, 15, 2);
      check_eq("relock_mv_count", s_mv_cnt - mv0, 1);
      check_eq("relock_period",   s_period, 30);
      check_eq("relock_locked",   {31'd0, s_locked}, 1);

      // boundary: period equal to the limit is measured
      do_reset();
      mv0 = s_mv_cnt;
      to0 = s_to_cnt;
      wave(100, 50, 3);
      check_eq("bound100_mv",     s_mv_cnt - mv0, 2);
      check_eq("bound100_to",     s_to_cnt - to0, 0);
      check_eq("bound100_period", s_period, 100);
      check_eq("bound100_high",   s_high,   50);
      tick(20);

      // one cycle over the limit times out every period
      do_reset();
      mv0 = s_mv_cnt;
      to0 = s_to_cnt;
      wave(101, 50, 3);
      tick(110);
      check_eq("bound101_mv",     s_mv_cnt - mv0, 0);
      check_eq("bound101_to",     s_to_cnt - to0, 3);
      check_eq("bound101_period", s_period, 0);

      // reset mid-period clears everything; next measurement is clean
      do_reset();
      wave(20, 10, 3);
      sig_in = 1'b1;
      tick(5);
      rst    = 1'b1;
      sig_in = 1'b0;
      tick(1);
      check_eq("midrst_period", s_period, 0);
      check_eq("midrst_high",   s_high,   0);
      check_eq("midrst_locked", {31'd0, s_locked}, 0);
      check_eq("midrst_mv",     {31'd0, s_mv},     0);
      rst = 1'b0;
      tick(5);
      mv0 = s_mv_cnt;
      wave(20, 10, 3);
      check_eq("postrst_mv",     s_mv_cnt - mv0, 2);
      check_eq("postrst_period", s_period, 20);
      check_eq("postrst_high",   s_high,   10);

      // enable drop while locked: unlock without a timeout strobe
      to0 = s_to_cnt;
      en = 1'b0;
      tick(2);
      check_eq("en_low_locked", {31'd0, s_locked}, 0);
      tick(3);
      en = 1'b1;
      check_eq("en_low_no_to", s_to_cnt - to0, 0);
      mv0 = s_mv_cnt;
      wave(20, 10, 3);
      check_eq("en_relock_mv",     s_mv_cnt - mv0, 2);
      check_eq("en_relock_locked", {31'd0, s_locked}, 1);
      check_eq("en_relock_period", s_period, 20);

      // single-cycle glitch on an idle line: one RUN entry, then timeout
      do_reset();
      tick(10);
      mv0 = s_mv_cnt;
      to0 = s_to_cnt;
      sig_in = 1'b1;
      tick(1);
      sig_in = 1'b0;
      tick(150);
      check_eq("glitch_mv",     s_mv_cnt - mv0, 0);
      check_eq("glitch_to",     s_to_cnt - to0, 1);
      check_eq("glitch_locked", {31'd0, s_locked}, 0);
      check_eq("glitch_period", s_period, 0);
      check_eq("no_x_outputs",  x_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
